wakeup_issue_queue: RTL and testbench
=====================================

// Module: wakeup_issue_queue
// PURPOSE
//  DEPTH-entry issue queue with tag wakeup and oldest-ready select for one functional unit.
//  Sits between the instruction router and one FU. Owns its PRF read ports and its output register.
//  Snoops writeback broadcasts from all FU_COUNT units, including its own FU, for same-queue back-to-back wakeup.
//  Drives a registered issue stage with fu_ready backpressure and a synchronous flush.
// PARAMETERS
//  INST_ID_BITS  6  instruction ID width
//  PRN_BITS      6  physical register number width
//  MAX_OPERANDS  3  source/dest operand slots per instruction
//  FU_COUNT      4  number of writeback broadcast buses snooped (own FU included)
//  DEPTH         8  queue entries, >=2; need not be a power of 2
// PORTS
//  clk               in   1                          clock
//  rst               in   1                          synchronous reset, active-low
//  flush             in   1                          discard all queued and staged work
//  inst_valid        in   1                          enqueue request
//  queue_ready       out  1                          entry free
//  inst_id           in   INST_ID_BITS               enqueued instruction ID
//  raw_instr         in   32                         encoding
//  instr_pc          in   64                         PC
//  prn_input_valid   in   [MAX_OPERANDS]x1           source slot used
//  prn_input_ready   in   [MAX_OPERANDS]x1           source already in PRF
//  prn_input         in   [MAX_OPERANDS]xPRN_BITS    source PRNs
//  prn_output_valid  in   [MAX_OPERANDS]x1           dest slot used
//  prn_output        in   [MAX_OPERANDS]xPRN_BITS    dest PRNs
//  set_prn_ready     in   [FU_COUNT][MAX_OPERANDS]x1 broadcast valid
//  set_prn           in   [FU_COUNT][MAX_OPERANDS]xPRN_BITS broadcast PRN
//  prf_read_enable   out  [MAX_OPERANDS]x1           PRF read strobe
//  prf_read_prn      out  [MAX_OPERANDS]xPRN_BITS    PRF read address
//  prf_op            in   [MAX_OPERANDS]x64          PRF data, combinational, same cycle
//  fu_ready          in   1                          FU accepts the issue register
//  issue_valid       out  1                          issue register holds an instruction
//  issue_inst_id / issue_instr / issue_pc  out  INST_ID_BITS/32/64  issued fields
//  issue_op          out  [MAX_OPERANDS]x64          operand data (0 for unused slots)
//  issue_prn_out_valid / issue_prn_out  out  [MAX_OPERANDS]x1 / xPRN_BITS  destinations
// BEHAVIOUR
//  Reset (rst=0 at posedge): all entries invalid, count=0, issue_valid=0, all issue_* data=0.
//   prf_read_enable=0 while rst=0; queue_ready=1 after reset.
//  queue_ready = (count != DEPTH); derived from registered state only.
//   No dependence on inst_valid or on same-cycle dequeue.
//  Enqueue fires when inst_valid & queue_ready. Ops ready on entry:
//   - ready[k] = !prn_input_valid[k] | prn_input_ready[k] | same-cycle broadcast hit on prn_input[k].
//  Wakeup, each cycle: for every valid entry, each operand k with prn_input_valid[k]:
//   - any f,o with set_prn_ready[f][o] & set_prn[f][o]==prn[k] sets ready[k] at the clock edge.
//  Select: an entry is eligible when all operand slots are ready.
//   - The oldest eligible entry (strict enqueue order) is chosen when the stage advances.
//   - stage advances = !issue_valid | fu_ready.
//  Select cycle N: prf_read_enable[k]=prn_input_valid[k], prf_read_prn=entry PRNs.
//   - prf_op is captured into the issue register at edge N.
//   - issue_valid=1 from N+1; the entry frees at edge N.
//   - Min latency: enqueue at edge E with ready operands -> issue_valid at E+2.
//  Backpressure: issue_valid & !fu_ready holds all issue_* stable and suppresses select and PRF reads.
//   - issue_valid=1 & fu_ready=1 with nothing eligible -> issue_valid=0 next cycle.
//  Simultaneous enqueue+select: count unchanged; a freed slot is reusable next cycle, not the same cycle.
//   - Full queue + select: queue_ready still 0 in that cycle.
//  flush=1 (flush takes priority over enqueue/select, rst over all):
//   - next cycle: all entries invalid, count=0, issue_valid=0.
//   - enqueue that cycle is dropped.
//  Own FU writeback appears on its set_prn row; no internal bypass beyond the broadcast.
// TESTING
//  Enqueue id=5, all ops ready, fu_ready=1 -> prf_read_enable asserted next cycle; issue_valid, id=5, prf_op data 2 cycles after enqueue.
//  Enqueue id1 (src P9 not ready) then id2 (ready); broadcast P9 on FU3 -> id2 issues first, then id1 one cycle after the wakeup edge.
//  Fill DEPTH=8 with waiting entries -> queue_ready=0 and inst_valid ignored; wake one -> queue_ready=1 the cycle after it is selected.
//  Two ready entries, fu_ready=0 for 3 cycles -> issue_* constant; no PRF reads; second issues 1 cycle after fu_ready=1.
//  flush with 4 entries plus a staged issue -> issue_valid=0, queue_ready=1, no later issue of the flushed IDs.
//  rst=0 asserted mid-stall -> all outputs at reset values next edge; enqueue works the cycle after rst=1.

Source files
------------

// File: rtl/wakeup_issue_queue.sv
// wakeup_issue_queue
//  Issue queue for a single functional unit. Instructions enter from the
//  router with their source/destination physical registers. Sources are
//  woken by writeback broadcasts from every FU, including this one. Each
//  cycle the oldest entry whose sources are all ready is selected. Its
//  operands are read from the PRF in the same cycle and latched into a
//  registered issue stage that the FU drains under fu_ready backpressure.
//
//  Ports
//   clk, rst (sync, active-low), flush      : clock / reset / discard-all
//   inst_valid, queue_ready, inst_id,
//   raw_instr, instr_pc, prn_input_*,
//   prn_output_*                             : enqueue side
//   set_prn_ready, set_prn                   : writeback broadcast snoop
//   prf_read_enable, prf_read_prn, prf_op    : PRF read port (data same cycle)
//   fu_ready, issue_*                        : registered issue stage to the FU
module wakeup_issue_queue #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int DEPTH        = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             flush,
    input  logic                                             inst_valid,
    output logic                                             queue_ready,
    input  logic [INST_ID_BITS-1:0]                          inst_id,
    input  logic [31:0]                                      raw_instr,
    input  logic [63:0]                                      instr_pc,
    input  logic [MAX_OPERANDS-1:0]                          prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                          prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prn_input,
    input  logic [MAX_OPERANDS-1:0]                          prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prn_output,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]            set_prn_ready,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    output logic [MAX_OPERANDS-1:0]                          prf_read_enable,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prf_read_prn,
    input  logic [MAX_OPERANDS-1:0][63:0]                    prf_op,
    input  logic                                             fu_ready,
    output logic                                             issue_valid,
    output logic [INST_ID_BITS-1:0]                          issue_inst_id,
    output logic [31:0]                                      issue_instr,
    output logic [63:0]                                      issue_pc,
    output logic [MAX_OPERANDS-1:0][63:0]                    issue_op,
    output logic [MAX_OPERANDS-1:0]                          issue_prn_out_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            issue_prn_out
);

    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // True when any broadcast lane carries the given PRN this cycle.
    function automatic logic bcast_hit(
        input logic [PRN_BITS-1:0]                             prn,
        input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]           bvalid,
        input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] bprn
    );
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int o = 0; o < MAX_OPERANDS; o++) begin
                if (bvalid[f][o] && (bprn[f][o] == prn)) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Entry storage
    logic [DEPTH-1:0]                         valid_reg;
    logic [INST_ID_BITS-1:0]                  id_reg        [DEPTH];
    logic [31:0]                              instr_reg     [DEPTH];
    logic [63:0]                              pc_reg        [DEPTH];
    logic [MAX_OPERANDS-1:0]                  src_valid_reg [DEPTH];
    logic [MAX_OPERANDS-1:0]                  src_ready_reg [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    src_prn_reg   [DEPTH];
    logic [MAX_OPERANDS-1:0]                  dst_valid_reg [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    dst_prn_reg   [DEPTH];
    // Age matrix: older_reg[i][j] = entry i was enqueued before entry j.
    // A slot's row is cleared and its column rebuilt whenever it is written,
    // so stale bits left behind by freed entries never matter.
    logic [DEPTH-1:0]                         older_reg     [DEPTH];
    logic [CNT_BITS-1:0]                      count_reg;

    logic [DEPTH-1:0]                         eligible;
    logic [DEPTH-1:0]                         sel_onehot;
    logic [DEPTH-1:0][MAX_OPERANDS-1:0]       wake_hit;
    logic [MAX_OPERANDS-1:0]                  enq_ready;
    logic [IDX_BITS-1:0]                      enq_idx;
    logic [IDX_BITS-1:0]                      sel_idx;
    logic                                     stage_adv;
    logic                                     sel_fire;
    logic                                     enq_fire;

    genvar gi, gk;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DEPTH-1:0] older_than_me;
            for (gk = 0; gk < DEPTH; gk++) begin : g_age
                assign older_than_me[gk] = older_reg[gk][gi];
            end
            // Unused source slots are marked ready at enqueue, so an entry
            // is eligible once every ready bit is set.
            assign eligible[gi]   = valid_reg[gi] & (&src_ready_reg[gi]);
            assign sel_onehot[gi] = eligible[gi] & ~(|(eligible & older_than_me));
            for (gk = 0; gk < MAX_OPERANDS; gk++) begin : g_wake
                assign wake_hit[gi][gk] = src_valid_reg[gi][gk] &
                    bcast_hit(src_prn_reg[gi][gk], set_prn_ready, set_prn);
            end
        end
        for (gk = 0; gk < MAX_OPERANDS; gk++) begin : g_enq_ready
            assign enq_ready[gk] = ~prn_input_valid[gk] | prn_input_ready[gk] |
                bcast_hit(prn_input[gk], set_prn_ready, set_prn);
        end
    endgenerate

    // Lowest free slot for enqueue; index of the one-hot oldest-ready pick.
    always_comb begin
        enq_idx = '0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) enq_idx = IDX_BITS'(i);
            if (sel_onehot[i]) sel_idx = IDX_BITS'(i);
        end
    end

    // queue_ready comes from the registered count only, so a slot freed by
    // this cycle's select is not offered until the next cycle.
    assign queue_ready = (count_reg != CNT_BITS'(DEPTH));
    assign stage_adv   = ~issue_valid | fu_ready;
    assign sel_fire    = rst & stage_adv & (|eligible);
    assign enq_fire    = inst_valid & queue_ready & ~flush;

    always_comb begin
        prf_read_enable = '0;
        prf_read_prn    = '0;
        if (sel_fire) begin
            prf_read_enable = src_valid_reg[sel_idx];
            prf_read_prn    = src_prn_reg[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_reg[i]) src_ready_reg[i] <= src_ready_reg[i] | wake_hit[i];
            end
            if (sel_fire) valid_reg[sel_idx] <= 1'b0;
            if (enq_fire) begin
                valid_reg[enq_idx]     <= 1'b1;
                id_reg[enq_idx]        <= inst_id;
                instr_reg[enq_idx]     <= raw_instr;
                pc_reg[enq_idx]        <= instr_pc;
                src_valid_reg[enq_idx] <= prn_input_valid;
                src_ready_reg[enq_idx] <= enq_ready;
                src_prn_reg[enq_idx]   <= prn_input;
                dst_valid_reg[enq_idx] <= prn_output_valid;
                dst_prn_reg[enq_idx]   <= prn_output;
                older_reg[enq_idx]     <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != int'(enq_idx)) older_reg[j][enq_idx] <= valid_reg[j];
                end
            end
            count_reg <= count_reg + CNT_BITS'(enq_fire) - CNT_BITS'(sel_fire);
        end
    end

    // Issue register: loads only when the stage advances; held under stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_valid         <= 1'b0;
            issue_inst_id       <= '0;
            issue_instr         <= '0;
            issue_pc            <= '0;
            issue_op            <= '0;
            issue_prn_out_valid <= '0;
            issue_prn_out       <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (stage_adv) begin
            issue_valid <= sel_fire;
            if (sel_fire) begin
                issue_inst_id       <= id_reg[sel_idx];
                issue_instr         <= instr_reg[sel_idx];
                issue_pc            <= pc_reg[sel_idx];
                issue_prn_out_valid <= dst_valid_reg[sel_idx];
                issue_prn_out       <= dst_prn_reg[sel_idx];
                for (int k = 0; k < MAX_OPERANDS; k++) begin
                    issue_op[k] <= src_valid_reg[sel_idx][k] ? prf_op[k] : 64'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wakeup_issue_queue.sv
module tb_wakeup_issue_queue;

    localparam int D = 8;

    logic             clk = 1'b0;
    logic             rst, flush, inst_valid, queue_ready;
    logic [5:0]       inst_id;
    logic [31:0]      raw_instr;
    logic [63:0]      instr_pc;
    logic [2:0]       prn_input_valid, prn_input_ready, prn_output_valid;
    logic [2:0][5:0]  prn_input, prn_output;
    logic [3:0][2:0]  set_prn_ready;
    logic [3:0][2:0][5:0] set_prn;
    logic [2:0]       prf_read_enable;
    logic [2:0][5:0]  prf_read_prn;
    logic [2:0][63:0] prf_op;
    logic             fu_ready, issue_valid;
    logic [5:0]       issue_inst_id;
    logic [31:0]      issue_instr;
    logic [63:0]      issue_pc;
    logic [2:0][63:0] issue_op;
    logic [2:0]       issue_prn_out_valid;
    logic [2:0][5:0]  issue_prn_out;

    logic [63:0] prf_mem [64];

    int checks = 0;
    int errors = 0;

    wakeup_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .inst_valid(inst_valid),
        .queue_ready(queue_ready), .inst_id(inst_id), .raw_instr(raw_instr),
        .instr_pc(instr_pc), .prn_input_valid(prn_input_valid),
        .prn_input_ready(prn_input_ready), .prn_input(prn_input),
        .prn_output_valid(prn_output_valid), .prn_output(prn_output),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn),
        .prf_read_enable(prf_read_enable), .prf_read_prn(prf_read_prn),
        .prf_op(prf_op), .fu_ready(fu_ready), .issue_valid(issue_valid),
        .issue_inst_id(issue_inst_id), .issue_instr(issue_instr),
        .issue_pc(issue_pc), .issue_op(issue_op),
        .issue_prn_out_valid(issue_prn_out_valid), .issue_prn_out(issue_prn_out)
    );

    always #5 clk = ~clk;

    // Register file answers the read address combinationally.
    always_comb begin
        for (int k = 0; k < 3; k++) prf_op[k] = prf_mem[prf_read_prn[k]];
    end

    // Reference model: an in-order list of waiting instructions plus the
    // expected contents of the issue stage.
    typedef struct {
        logic [5:0]      id;
        logic [31:0]     instr;
        logic [63:0]     pc;
        logic [2:0]      sv;
        logic [2:0]      sr;
        logic [2:0][5:0] sp;
        logic [2:0]      dv;
        logic [2:0][5:0] dp;
    } ent_t;

    ent_t             mq[$];
    logic             m_iv;
    logic [5:0]       m_id;
    logic [31:0]      m_instr;
    logic [63:0]      m_pc;
    logic [2:0][63:0] m_op;
    logic [2:0]       m_dv;
    logic [2:0][5:0]  m_dp;

    logic             obs_qr, exp_qr;
    logic [2:0]       obs_ren, exp_ren;
    logic [2:0][5:0]  obs_rprn, exp_rprn;

    function automatic bit bhit(input logic [5:0] p);
        for (int f = 0; f < 4; f++)
            for (int o = 0; o < 3; o++)
                if (set_prn_ready[f][o] && set_prn[f][o] == p) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: sample pre-edge outputs, derive expectations, advance model.
    task automatic step();
        int   sel;
        int   n_before;
        logic adv;
        ent_t e;
        ent_t n;
        @(negedge clk);
        obs_qr   = queue_ready;
        obs_ren  = prf_read_enable;
        obs_rprn = prf_read_prn;
        exp_qr   = (mq.size() != D);
        adv      = !m_iv || fu_ready;
        sel      = -1;
        if (adv) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].sr == 3'b111) begin sel = i; break; end
            end
        end
        exp_ren  = '0;
        exp_rprn = '0;
        if (rst && sel >= 0) begin
            exp_ren  = mq[sel].sv;
            exp_rprn = mq[sel].sp;
        end
        if (!rst) begin
            mq.delete();
            m_iv = 0; m_id = '0; m_instr = '0; m_pc = '0; m_op = '0; m_dv = '0; m_dp = '0;
        end else if (flush) begin
            mq.delete();
            m_iv = 0;
        end else begin
            n_before = mq.size();
            if (sel >= 0) begin
                e = mq[sel];
                m_iv = 1; m_id = e.id; m_instr = e.instr; m_pc = e.pc;
                m_dv = e.dv; m_dp = e.dp;
                for (int k = 0; k < 3; k++) m_op[k] = e.sv[k] ? prf_mem[e.sp[k]] : 64'd0;
                mq.delete(sel);
            end else if (adv) begin
                m_iv = 0;
            end
            for (int i = 0; i < mq.size(); i++)
                for (int k = 0; k < 3; k++)
                    if (mq[i].sv[k] && bhit(mq[i].sp[k])) mq[i].sr[k] = 1'b1;
            if (inst_valid && n_before != D) begin
                n.id = inst_id; n.instr = raw_instr; n.pc = instr_pc;
                n.sv = prn_input_valid; n.sp = prn_input;
                n.dv = prn_output_valid; n.dp = prn_output;
                for (int k = 0; k < 3; k++)
                    n.sr[k] = !prn_input_valid[k] || prn_input_ready[k] || bhit(prn_input[k]);
                mq.push_back(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        inst_valid = 0; flush = 0; set_prn_ready = '0; set_prn = '0;
        prn_input_valid = '0; prn_input_ready = '0; prn_input = '0;
        prn_output_valid = '0; prn_output = '0;
    endtask

    task automatic drive_enq(input logic [5:0] id, input logic [2:0] sv, input logic [2:0] sr,
                             input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
        inst_valid = 1; inst_id = id;
        raw_instr = 32'hA5A5_0000 | {26'd0, id};
        instr_pc = 64'h1000 + {58'd0, id};
        prn_input_valid = sv; prn_input_ready = sr;
        prn_input[0] = p0; prn_input[1] = p1; prn_input[2] = p2;
        prn_output_valid = 3'b001; prn_output = '0; prn_output[0] = id + 6'd32;
    endtask

    task automatic do_reset();
        set_idle(); rst = 0; step(); rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; fu_ready = 1;
        drive_enq(6'd33, 3'b111, 3'b111, 6'd1, 6'd2, 6'd3);
        step(); step();
        checks++; if (obs_ren !== 3'b000) begin errors++; $display("FAIL reset_prf_en got %b exp 000", obs_ren); end
        rst = 1; set_idle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
        checks++; if (issue_inst_id !== 6'd0 || issue_pc !== 64'd0 || issue_op !== '0 || issue_prn_out_valid !== 3'd0) begin
            errors++; $display("FAIL reset_issue_data id %0d pc %h exp zero", issue_inst_id, issue_pc); end
        checks++; if (queue_ready !== 1'b1) begin errors++; $display("FAIL reset_queue_ready got %b exp 1", queue_ready); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_no_issue got %b exp 0", issue_valid); end
    endtask

    task automatic test_basic_issue();
        do_reset(); fu_ready = 1;
        drive_enq(6'd5, 3'b111, 3'b111, 6'd10, 6'd11, 6'd12); step();
        checks++; if (obs_ren !== 3'b000) begin errors++; $display("FAIL basic_enq_cycle_ren got %b exp 000", obs_ren); end
        set_idle(); step();
        checks++; if (obs_ren !== 3'b111 || obs_rprn[0] !== 6'd10 || obs_rprn[2] !== 6'd12) begin
            errors++; $display("FAIL basic_prf_read ren %b prn0 %0d exp 111/10", obs_ren, obs_rprn[0]); end
        checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd5) begin
            errors++; $display("FAIL basic_issue valid %b id %0d exp 1/5", issue_valid, issue_inst_id); end
        checks++; if (issue_op[0] !== prf_mem[10] || issue_op[2] !== prf_mem[12]) begin
            errors++; $display("FAIL basic_ops got %h exp %h", issue_op[0], prf_mem[10]); end
        checks++; if (issue_instr !== 32'hA5A5_0005 || issue_pc !== 64'h1005 || issue_prn_out_valid !== 3'b001 || issue_prn_out[0] !== 6'd37) begin
            errors++; $display("FAIL basic_fields instr %h pc %h dst %0d exp a5a50005/1005/37", issue_instr, issue_pc, issue_prn_out[0]); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", issue_valid); end
    endtask

    task automatic test_wakeup_order();
        do_reset(); fu_ready = 1;
        drive_enq(6'd1, 3'b001, 3'b000, 6'd9, 6'd0, 6'd0); step();
        drive_enq(6'd2, 3'b001, 3'b001, 6'd3, 6'd0, 6'd0); step();
        checks++; if (obs_ren !== 3'b000) begin errors++; $display("FAIL wake_none_ready ren %b exp 000", obs_ren); end
        set_idle(); set_prn_ready[3][1] = 1'b1; set_prn[3][1] = 6'd9; step();
        checks++; if (obs_ren !== 3'b001 || obs_rprn[0] !== 6'd3) begin
            errors++; $display("FAIL wake_sel_young ren %b prn %0d exp 001/3", obs_ren, obs_rprn[0]); end
        checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd2) begin
            errors++; $display("FAIL wake_first_issue id %0d exp 2", issue_inst_id); end
        set_idle(); step();
        checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd1 || issue_op[0] !== prf_mem[9]) begin
            errors++; $display("FAIL wake_second_issue id %0d exp 1", issue_inst_id); end
        checks++; if (issue_op[1] !== 64'd0 || issue_op[2] !== 64'd0) begin
            errors++; $display("FAIL wake_unused_ops got %h exp 0", issue_op[1]); end
    endtask

    task automatic test_full();
        do_reset(); fu_ready = 1;
        for (int i = 0; i < D; i++) begin
            drive_enq(6'(10 + i), 3'b001, 3'b000, 6'(40 + i), 6'd0, 6'd0); step();
        end
        checks++; if (queue_ready !== 1'b0) begin errors++; $display("FAIL full_queue_ready got %b exp 0", queue_ready); end
        drive_enq(6'd60, 3'b001, 3'b001, 6'd1, 6'd0, 6'd0); step();
        checks++; if (obs_qr !== 1'b0 || obs_ren !== 3'b000) begin
            errors++; $display("FAIL full_ignore qr %b ren %b exp 0/000", obs_qr, obs_ren); end
        set_idle(); set_prn_ready[0][0] = 1'b1; set_prn[0][0] = 6'd43; step();
        checks++; if (queue_ready !== 1'b0) begin errors++; $display("FAIL full_wake_edge qr %b exp 0", queue_ready); end
        set_idle(); step();
        checks++; if (obs_qr !== 1'b0 || obs_ren !== 3'b001 || obs_rprn[0] !== 6'd43) begin
            errors++; $display("FAIL full_select qr %b ren %b prn %0d exp 0/001/43", obs_qr, obs_ren, obs_rprn[0]); end
        checks++; if (queue_ready !== 1'b1 || issue_inst_id !== 6'd13) begin
            errors++; $display("FAIL full_freed qr %b id %0d exp 1/13", queue_ready, issue_inst_id); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL full_dropped_enq got %b exp 0", issue_valid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] held_op;
        do_reset(); fu_ready = 0;
        drive_enq(6'd21, 3'b111, 3'b111, 6'd4, 6'd5, 6'd6); step();
        drive_enq(6'd22, 3'b001, 3'b001, 6'd7, 6'd0, 6'd0); step();
        set_idle();
        checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd21 || issue_op[0] !== prf_mem[4]) begin
            errors++; $display("FAIL bp_first id %0d exp 21", issue_inst_id); end
        held_op = issue_op[0];
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (obs_ren !== 3'b000) begin errors++; $display("FAIL bp_no_read cyc %0d ren %b exp 000", c, obs_ren); end
            checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd21 || issue_op[0] !== held_op) begin
                errors++; $display("FAIL bp_hold cyc %0d id %0d exp 21", c, issue_inst_id); end
        end
        fu_ready = 1; step();
        checks++; if (obs_ren !== 3'b001 || issue_inst_id !== 6'd22) begin
            errors++; $display("FAIL bp_release ren %b id %0d exp 001/22", obs_ren, issue_inst_id); end
    endtask

    task automatic test_flush();
        do_reset(); fu_ready = 0;
        drive_enq(6'd30, 3'b001, 3'b001, 6'd8, 6'd0, 6'd0); step();
        for (int i = 0; i < 4; i++) begin
            drive_enq(6'(31 + i), 3'b001, 3'b000, 6'd50, 6'd0, 6'd0); step();
        end
        checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd30) begin
            errors++; $display("FAIL flush_staged id %0d exp 30", issue_inst_id); end
        drive_enq(6'd40, 3'b001, 3'b001, 6'd2, 6'd0, 6'd0); flush = 1; step();
        set_idle();
        checks++; if (issue_valid !== 1'b0 || queue_ready !== 1'b1) begin
            errors++; $display("FAIL flush_clear valid %b qr %b exp 0/1", issue_valid, queue_ready); end
        fu_ready = 1; set_prn_ready[2][0] = 1'b1; set_prn[2][0] = 6'd50; step();
        set_idle();
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (issue_valid !== 1'b0) begin
                errors++; $display("FAIL flush_no_issue cyc %0d id %0d exp none", c, issue_inst_id); end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset(); fu_ready = 0;
        drive_enq(6'd44, 3'b001, 3'b001, 6'd12, 6'd0, 6'd0); step();
        drive_enq(6'd45, 3'b001, 3'b001, 6'd13, 6'd0, 6'd0); step();
        set_idle(); step();
        checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd44) begin
            errors++; $display("FAIL rst_stall_pre id %0d exp 44", issue_inst_id); end
        rst = 0; step();
        checks++; if (obs_ren !== 3'b000) begin errors++; $display("FAIL rst_stall_ren got %b exp 000", obs_ren); end
        checks++; if (issue_valid !== 1'b0 || issue_inst_id !== 6'd0 || issue_op !== '0 || queue_ready !== 1'b1) begin
            errors++; $display("FAIL rst_stall_outputs valid %b id %0d qr %b exp 0/0/1", issue_valid, issue_inst_id, queue_ready); end
        rst = 1; fu_ready = 1;
        drive_enq(6'd7, 3'b001, 3'b001, 6'd14, 6'd0, 6'd0); step();
        set_idle(); step();
        checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd7) begin
            errors++; $display("FAIL rst_stall_enq id %0d exp 7", issue_inst_id); end
    endtask

    task automatic test_random();
        logic [5:0] next_id;
        logic       bad;
        next_id = 6'd0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = 1;
            flush = ($urandom_range(0, 49) == 0);
            fu_ready = ($urandom_range(0, 9) < 7);
            inst_valid = 1'($urandom_range(0, 1));
            inst_id = next_id;
            if (inst_valid) next_id = next_id + 6'd1;
            raw_instr = $urandom;
            instr_pc = {$urandom, $urandom};
            prn_input_valid = 3'($urandom);
            prn_output_valid = 3'($urandom);
            for (int k = 0; k < 3; k++) begin
                prn_input_ready[k] = ($urandom_range(0, 2) == 0);
                prn_input[k] = 6'($urandom_range(0, 15));
                prn_output[k] = 6'($urandom);
            end
            for (int f = 0; f < 4; f++)
                for (int o = 0; o < 3; o++) begin
                    set_prn_ready[f][o] = ($urandom_range(0, 7) == 0);
                    set_prn[f][o] = 6'($urandom_range(0, 15));
                end
            step();
            checks++; if (obs_qr !== exp_qr) begin
                errors++; $display("FAIL rnd_queue_ready cyc %0d got %b exp %b", c, obs_qr, exp_qr); end
            checks++; if (obs_ren !== exp_ren) begin
                errors++; $display("FAIL rnd_prf_en cyc %0d got %b exp %b", c, obs_ren, exp_ren); end
            bad = 0;
            for (int k = 0; k < 3; k++) if (exp_ren[k] && obs_rprn[k] !== exp_rprn[k]) bad = 1;
            checks++; if (bad) begin
                errors++; $display("FAIL rnd_prf_prn cyc %0d got %h exp %h", c, obs_rprn, exp_rprn); end
            checks++; if (issue_valid !== m_iv) begin
                errors++; $display("FAIL rnd_issue_valid cyc %0d got %b exp %b", c, issue_valid, m_iv); end
            if (m_iv) begin
                checks++;
                if ({issue_inst_id, issue_instr, issue_pc, issue_op, issue_prn_out_valid, issue_prn_out} !==
                    {m_id, m_instr, m_pc, m_op, m_dv, m_dp}) begin
                    errors++; $display("FAIL rnd_issue_data cyc %0d id %0d pc %h op0 %h exp id %0d pc %h op0 %h",
                                       c, issue_inst_id, issue_pc, issue_op[0], m_id, m_pc, m_op[0]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prf_mem[i] = {$urandom, $urandom};
        rst = 0; fu_ready = 1; inst_id = '0; raw_instr = '0; instr_pc = '0;
        set_idle();
        m_iv = 0; m_id = '0; m_instr = '0; m_pc = '0; m_op = '0; m_dv = '0; m_dp = '0;
        test_reset();
        test_basic_issue();
        test_wakeup_order();
        test_full();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
